// File: rtl/bfs_system_integrated.sv
// rtl/bfs_system_integrated.sv - AXI-Lite configured BFS engine over 64-node adjacency-row bitmaps
// Rows are fetched one at a time over AXI4 reads; a 64-entry {level,node} FIFO drives the traversal.
module bfs_system_integrated #(
    parameter int AXI_ADDR_WIDTH = 12,
    parameter int AXI_DATA_WIDTH = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [AXI_ADDR_WIDTH-1:0] s_axi_lite_awaddr,
    input  logic                      s_axi_lite_awvalid,
    output logic                      s_axi_lite_awready,
    input  logic [31:0]               s_axi_lite_wdata,
    input  logic [3:0]                s_axi_lite_wstrb,
    input  logic                      s_axi_lite_wvalid,
    output logic                      s_axi_lite_wready,
    output logic [1:0]                s_axi_lite_bresp,
    output logic                      s_axi_lite_bvalid,
    input  logic                      s_axi_lite_bready,
    input  logic [AXI_ADDR_WIDTH-1:0] s_axi_lite_araddr,
    input  logic                      s_axi_lite_arvalid,
    output logic                      s_axi_lite_arready,
    output logic [31:0]               s_axi_lite_rdata,
    output logic [1:0]                s_axi_lite_rresp,
    output logic                      s_axi_lite_rvalid,
    input  logic                      s_axi_lite_rready,
    output logic [31:0]               m_axi_araddr,
    output logic [7:0]                m_axi_arlen,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    input  logic [AXI_DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rlast,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready,
    output logic                      global_done
);

    localparam int WW = AXI_ADDR_WIDTH - 2;
    localparam logic [WW-1:0] REG_CTRL   = WW'(0);
    localparam logic [WW-1:0] REG_START  = WW'(1);
    localparam logic [WW-1:0] REG_BASE   = WW'(2);
    localparam logic [WW-1:0] REG_NUM    = WW'(3);
    localparam logic [WW-1:0] REG_STATUS = WW'(4);
    localparam logic [WW-1:0] REG_VIS_LO = WW'(5);
    localparam logic [WW-1:0] REG_VIS_HI = WW'(6);

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_DEQ, S_AR, S_R, S_SCAN, S_DONE
    } state_t;

    function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[b*8 +: 8] = strb[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
        end
        return r;
    endfunction

    function automatic logic [5:0] lowest_bit(input logic [63:0] v);
        logic [5:0] idx;
        idx = '0;
        for (int i = 63; i >= 0; i--) begin
            if (v[i]) idx = 6'(i);
        end
        return idx;
    endfunction

    // Register-file and lite-channel state
    logic          awready_q, bvalid_q, arready_q, rvalid_q;
    logic [31:0]   rdata_q, rd_mux;
    logic [31:0]   start_node_q, graph_base_q, num_nodes_q;
    logic          wr_en, rd_en, start_req;
    logic [WW-1:0] wr_word, rd_word;

    // Engine state
    state_t        state_q, state_d;
    logic          busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic [5:0]    run_start_q, run_start_d;
    logic [31:0]   run_base_q, run_base_d, run_num_q, run_num_d;
    logic [6:0]    count_q, count_d;
    logic [5:0]    level_q, level_d;
    logic [63:0]   visited_q, visited_d, new_q, new_d, node_mask;
    logic [5:0]    cur_node_q, cur_node_d, cur_level_q, cur_level_d, next_level, scan_id;
    logic          run_bad;

    // Traversal FIFO
    logic [11:0]   q_mem_q [64];
    logic [6:0]    wr_ptr_q, rd_ptr_q;
    logic          push, pop, q_clear, q_empty;
    logic [11:0]   push_data, q_head;

    assign wr_word   = s_axi_lite_awaddr[AXI_ADDR_WIDTH-1:2];
    assign rd_word   = s_axi_lite_araddr[AXI_ADDR_WIDTH-1:2];
    assign wr_en     = awready_q && s_axi_lite_awvalid && s_axi_lite_wvalid;
    assign rd_en     = arready_q && s_axi_lite_arvalid;
    assign start_req = wr_en && (wr_word == REG_CTRL) && s_axi_lite_wstrb[0]
                       && s_axi_lite_wdata[0] && (state_q == S_IDLE);

    always_comb begin
        rd_mux = '0;
        case (rd_word)
            REG_START:  rd_mux = start_node_q;
            REG_BASE:   rd_mux = graph_base_q;
            REG_NUM:    rd_mux = num_nodes_q;
            REG_STATUS: rd_mux = {10'd0, level_q, 1'b0, count_q, 5'd0, error_q, done_q, busy_q};
            REG_VIS_LO: rd_mux = visited_q[31:0];
            REG_VIS_HI: rd_mux = visited_q[63:32];
            default:    rd_mux = '0;
        endcase
    end

    // Ready strobes are registered so they stay low through reset regardless of the inputs
    always_ff @(posedge clk) begin
        if (rst) begin
            awready_q    <= 1'b0;
            bvalid_q     <= 1'b0;
            arready_q    <= 1'b0;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
            start_node_q <= '0;
            graph_base_q <= '0;
            num_nodes_q  <= '0;
        end else begin
            awready_q <= s_axi_lite_awvalid && s_axi_lite_wvalid && !bvalid_q && !awready_q;
            arready_q <= s_axi_lite_arvalid && !rvalid_q && !arready_q;
            if (wr_en) begin
                bvalid_q <= 1'b1;
            end else if (s_axi_lite_bready) begin
                bvalid_q <= 1'b0;
            end
            if (rd_en) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_mux;
            end else if (s_axi_lite_rready) begin
                rvalid_q <= 1'b0;
            end
            if (wr_en) begin
                case (wr_word)
                    REG_START: start_node_q <= apply_strb(start_node_q, s_axi_lite_wdata, s_axi_lite_wstrb);
                    REG_BASE:  graph_base_q <= apply_strb(graph_base_q, s_axi_lite_wdata, s_axi_lite_wstrb);
                    REG_NUM:   num_nodes_q  <= apply_strb(num_nodes_q, s_axi_lite_wdata, s_axi_lite_wstrb);
                    default:   ;
                endcase
            end
        end
    end

    always_comb begin
        node_mask = '0;
        for (int i = 0; i < 64; i++) begin
            node_mask[i] = (32'(i) < run_num_q);
        end
    end

    assign run_bad    = (run_num_q == 32'd0) || (run_num_q > 32'd64) || ({26'd0, run_start_q} >= run_num_q);
    assign q_empty    = (wr_ptr_q == rd_ptr_q);
    assign q_head     = q_mem_q[rd_ptr_q[5:0]];
    assign next_level = cur_level_q + 6'd1;
    assign scan_id    = lowest_bit(new_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            run_start_q <= '0;
            run_base_q  <= '0;
            run_num_q   <= '0;
            count_q     <= '0;
            level_q     <= '0;
            visited_q   <= '0;
            new_q       <= '0;
            cur_node_q  <= '0;
            cur_level_q <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            run_start_q <= run_start_d;
            run_base_q  <= run_base_d;
            run_num_q   <= run_num_d;
            count_q     <= count_d;
            level_q     <= level_d;
            visited_q   <= visited_d;
            new_q       <= new_d;
            cur_node_q  <= cur_node_d;
            cur_level_q <= cur_level_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        busy_d        = busy_q;
        done_d        = done_q;
        error_d       = error_q;
        run_start_d   = run_start_q;
        run_base_d    = run_base_q;
        run_num_d     = run_num_q;
        count_d       = count_q;
        level_d       = level_q;
        visited_d     = visited_q;
        new_d         = new_q;
        cur_node_d    = cur_node_q;
        cur_level_d   = cur_level_q;
        push          = 1'b0;
        push_data     = '0;
        pop           = 1'b0;
        q_clear       = 1'b0;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_req) begin
                    run_start_d = start_node_q[5:0];
                    run_base_d  = graph_base_q;
                    run_num_d   = num_nodes_q;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    error_d     = 1'b0;
                    count_d     = '0;
                    level_d     = '0;
                    visited_d   = '0;
                    q_clear     = 1'b1;
                    state_d     = S_INIT;
                end
            end
            S_INIT: begin
                if (run_bad) begin
                    error_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    visited_d[run_start_q] = 1'b1;
                    count_d   = 7'd1;
                    push      = 1'b1;
                    push_data = {6'd0, run_start_q};
                    state_d   = S_DEQ;
                end
            end
            S_DEQ: begin
                if (q_empty) begin
                    state_d = S_DONE;
                end else begin
                    pop         = 1'b1;
                    cur_level_d = q_head[11:6];
                    cur_node_d  = q_head[5:0];
                    state_d     = S_AR;
                end
            end
            S_AR: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) state_d = S_R;
            end
            S_R: begin
                m_axi_rready = 1'b1;
                if (m_axi_rvalid) begin
                    if (m_axi_rresp != 2'b00) begin
                        error_d = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        new_d   = m_axi_rdata & ~visited_q & node_mask;
                        state_d = S_SCAN;
                    end
                end
            end
            S_SCAN: begin
                if (new_q == 64'd0) begin
                    state_d = S_DEQ;
                end else begin
                    push      = 1'b1;
                    push_data = {next_level, scan_id};
                    visited_d[scan_id] = 1'b1;
                    count_d   = count_q + 7'd1;
                    if (next_level > level_q) level_d = next_level;
                    new_d     = new_q & (new_q - 64'd1);
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Push and pop never coincide: pushes come from INIT/SCAN, pops only from DEQ
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < 64; i++) q_mem_q[i] <= '0;
        end else if (q_clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) begin
                q_mem_q[wr_ptr_q[5:0]] <= push_data;
                wr_ptr_q <= wr_ptr_q + 7'd1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 7'd1;
        end
    end

    assign s_axi_lite_awready = awready_q;
    assign s_axi_lite_wready  = awready_q;
    assign s_axi_lite_bvalid  = bvalid_q;
    assign s_axi_lite_bresp   = 2'b00;
    assign s_axi_lite_arready = arready_q;
    assign s_axi_lite_rvalid  = rvalid_q;
    assign s_axi_lite_rdata   = rdata_q;
    assign s_axi_lite_rresp   = 2'b00;
    assign m_axi_araddr       = run_base_q + {23'd0, cur_node_q, 3'd0};
    assign m_axi_arlen        = 8'd0;
    assign global_done        = done_q;

    logic unused_ok;
    assign unused_ok = &{1'b0, m_axi_rlast, s_axi_lite_awaddr[1:0], s_axi_lite_araddr[1:0]};

endmodule

// File: tb/tb_bfs_system_integrated.sv
// tb/tb_bfs_system_integrated.sv - randomized BFS runs checked against a queue-based traversal model
module tb_bfs_system_integrated;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] s_axi_lite_awaddr, s_axi_lite_araddr;
    logic        s_axi_lite_awvalid, s_axi_lite_awready, s_axi_lite_wvalid, s_axi_lite_wready;
    logic [31:0] s_axi_lite_wdata, s_axi_lite_rdata;
    logic [3:0]  s_axi_lite_wstrb;
    logic [1:0]  s_axi_lite_bresp, s_axi_lite_rresp;
    logic        s_axi_lite_bvalid, s_axi_lite_bready, s_axi_lite_arvalid, s_axi_lite_arready;
    logic        s_axi_lite_rvalid, s_axi_lite_rready;
    logic [31:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic        m_axi_arvalid, m_axi_arready, m_axi_rlast, m_axi_rvalid, m_axi_rready;
    logic [63:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        global_done;

    always #5 clk = ~clk;

    bfs_system_integrated dut (
        .clk(clk), .rst(rst),
        .s_axi_lite_awaddr(s_axi_lite_awaddr), .s_axi_lite_awvalid(s_axi_lite_awvalid),
        .s_axi_lite_awready(s_axi_lite_awready), .s_axi_lite_wdata(s_axi_lite_wdata),
        .s_axi_lite_wstrb(s_axi_lite_wstrb), .s_axi_lite_wvalid(s_axi_lite_wvalid),
        .s_axi_lite_wready(s_axi_lite_wready), .s_axi_lite_bresp(s_axi_lite_bresp),
        .s_axi_lite_bvalid(s_axi_lite_bvalid), .s_axi_lite_bready(s_axi_lite_bready),
        .s_axi_lite_araddr(s_axi_lite_araddr), .s_axi_lite_arvalid(s_axi_lite_arvalid),
        .s_axi_lite_arready(s_axi_lite_arready), .s_axi_lite_rdata(s_axi_lite_rdata),
        .s_axi_lite_rresp(s_axi_lite_rresp), .s_axi_lite_rvalid(s_axi_lite_rvalid),
        .s_axi_lite_rready(s_axi_lite_rready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .global_done(global_done)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Graph memory and expected traffic shared with the responder
    logic [63:0] rows [64];
    logic [31:0] mem_base;
    int          err_at;
    logic [31:0] exp_addr [$];
    int          ridx;
    logic [31:0] first_addr;
    logic [31:0] exp_status;
    logic [63:0] exp_vis;
    logic [31:0] last_status, last_lo, last_hi;

    initial begin : responder
        int          phase;
        int          ar_dly, r_dly;
        logic [31:0] a, idx;
        logic [1:0]  resp;
        phase = 0; ar_dly = 0; r_dly = 0; resp = 2'b00;
        m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0;
        m_axi_rresp = 2'b00; m_axi_rlast = 1'b0;
        forever begin
            @(negedge clk);
            m_axi_arready = 1'b0;
            if (phase != 2) m_axi_rvalid = 1'b0;
            if (rst) begin
                phase = 0;
                m_axi_rvalid = 1'b0;
            end else begin
                case (phase)
                    0: begin
                        if (!m_axi_arvalid) begin
                            ar_dly = $urandom_range(0, 3);
                        end else if (ar_dly > 0) begin
                            ar_dly--;
                            // stray data before the address handshake must be ignored
                            if ($urandom_range(0, 1) == 1) begin
                                m_axi_rvalid = 1'b1;
                                m_axi_rdata  = '1;
                                m_axi_rresp  = 2'b10;
                            end
                        end else begin
                            m_axi_arready = 1'b1;
                            a = m_axi_araddr;
                            check("m_arlen", m_axi_arlen, 0);
                            if (ridx == 0) first_addr = a;
                            if (ridx < exp_addr.size()) check("m_araddr", a, exp_addr[ridx]);
                            else check("extra_read", ridx, exp_addr.size());
                            resp = (ridx == err_at) ? 2'b10 : 2'b00;
                            ridx++;
                            r_dly = $urandom_range(0, 4);
                            phase = 1;
                        end
                    end
                    1: begin
                        if (r_dly > 0) begin
                            r_dly--;
                        end else begin
                            idx = (a - mem_base) >> 3;
                            m_axi_rvalid = 1'b1;
                            m_axi_rdata  = rows[idx[5:0]];
                            m_axi_rresp  = resp;
                            m_axi_rlast  = 1'b1;
                            phase = m_axi_rready ? 3 : 2;
                        end
                    end
                    2: if (m_axi_rready) phase = 3;
                    default: begin
                        m_axi_rvalid = 1'b0;
                        phase = 0;
                    end
                endcase
            end
        end
    end

    task automatic lite_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] strb);
        int n;
        @(negedge clk);
        s_axi_lite_awaddr = a; s_axi_lite_wdata = d; s_axi_lite_wstrb = strb;
        s_axi_lite_awvalid = 1'b1; s_axi_lite_wvalid = 1'b1;
        n = 0;
        while (!s_axi_lite_awready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) check("lite_aw_timeout", 0, 1);
        check("lite_wready", s_axi_lite_wready, 1);
        @(posedge clk); #1;
        s_axi_lite_awvalid = 1'b0; s_axi_lite_wvalid = 1'b0; s_axi_lite_bready = 1'b1;
        n = 0;
        while (!s_axi_lite_bvalid && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) check("lite_b_timeout", 0, 1);
        @(posedge clk); #1;
        s_axi_lite_bready = 1'b0;
    endtask

    task automatic lite_read(input logic [11:0] a, output logic [31:0] d);
        int n;
        @(negedge clk);
        s_axi_lite_araddr = a; s_axi_lite_arvalid = 1'b1;
        n = 0;
        while (!s_axi_lite_arready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) check("lite_ar_timeout", 0, 1);
        @(posedge clk); #1;
        s_axi_lite_arvalid = 1'b0; s_axi_lite_rready = 1'b1;
        n = 0;
        while (!s_axi_lite_rvalid && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) check("lite_r_timeout", 0, 1);
        d = s_axi_lite_rdata;
        @(posedge clk); #1;
        s_axi_lite_rready = 1'b0;
    endtask

    // Level-order traversal, neighbours taken in ascending node id
    task automatic build_model(input logic [31:0] num, input logic [31:0] start,
                               input logic [31:0] base, input int err_idx);
        int q[$];
        int lvl[64];
        int s, n, cnt, maxl;
        logic err;
        exp_addr.delete();
        ridx = 0; err_at = err_idx; mem_base = base;
        exp_vis = '0; cnt = 0; maxl = 0; err = 1'b0;
        s = int'(start[5:0]);
        if (num == 0 || num > 64 || s >= int'(num)) begin
            err = 1'b1;
        end else begin
            exp_vis[s] = 1'b1; cnt = 1; lvl[s] = 0;
            q.push_back(s);
            while (q.size() > 0) begin
                n = q.pop_front();
                exp_addr.push_back(base + 32'(8 * n));
                if (exp_addr.size() - 1 == err_idx) begin
                    err = 1'b1;
                    break;
                end
                for (int i = 0; i < int'(num); i++) begin
                    if (rows[n][i] && !exp_vis[i]) begin
                        exp_vis[i] = 1'b1;
                        lvl[i] = lvl[n] + 1;
                        cnt++;
                        if (lvl[i] > maxl) maxl = lvl[i];
                        q.push_back(i);
                    end
                end
            end
        end
        exp_status = {10'd0, maxl[5:0], 1'b0, cnt[6:0], 5'd0, err, 1'b1, 1'b0};
    endtask

    task automatic program_and_start(input logic [31:0] num, input logic [31:0] start,
                                     input logic [31:0] base);
        lite_write(12'h00C, num, 4'hF);
        lite_write(12'h008, base, 4'hF);
        lite_write(12'h004, start, 4'hF);
        lite_write(12'h000, 32'h1, 4'hF);
    endtask

    task automatic run_bfs(input string tag, input logic [31:0] num, input logic [31:0] start,
                           input logic [31:0] base, input int err_idx, input bit probe);
        int n;
        logic [31:0] d;
        build_model(num, start, base, err_idx);
        program_and_start(num, start, base);
        if (probe) begin
            lite_read(12'h010, d);
            check({tag, "_busy"}, d[1:0], 2'b01);
            lite_write(12'h008, 32'h0000_8000, 4'hF);
        end
        n = 0;
        while (!global_done && n < 8000) begin @(negedge clk); n++; end
        check({tag, "_done"}, global_done, 1);
        lite_read(12'h010, last_status);
        check({tag, "_status"}, last_status, exp_status);
        lite_read(12'h014, last_lo);
        check({tag, "_vis_lo"}, last_lo, exp_vis[31:0]);
        lite_read(12'h018, last_hi);
        check({tag, "_vis_hi"}, last_hi, exp_vis[63:32]);
        check({tag, "_reads"}, ridx, exp_addr.size());
        if (probe) begin
            lite_read(12'h008, d);
            check({tag, "_base_rw"}, d, 32'h0000_8000);
        end
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [31:0] d, num, start, base;
        logic [63:0] v;
        int k, e;
        s_axi_lite_awaddr = '0; s_axi_lite_awvalid = 1'b0; s_axi_lite_wdata = '0;
        s_axi_lite_wstrb = '0; s_axi_lite_wvalid = 1'b0; s_axi_lite_bready = 1'b0;
        s_axi_lite_araddr = '0; s_axi_lite_arvalid = 1'b0; s_axi_lite_rready = 1'b0;
        ridx = 0; err_at = -1; mem_base = '0; first_addr = '0;
        for (int i = 0; i < 64; i++) rows[i] = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_outs", {m_axi_arvalid, m_axi_rready, s_axi_lite_awready, s_axi_lite_wready,
                           s_axi_lite_bvalid, s_axi_lite_arready, s_axi_lite_rvalid, global_done}, 0);
        @(negedge clk);
        rst = 1'b0;

        lite_read(12'h010, d);
        check("rst_status", d, 0);
        check("rst_global_done", global_done, 0);
        lite_write(12'h004, 32'h1234_5678, 4'hF);
        lite_read(12'h004, d);
        check("start_rw", d, 32'h1234_5678);
        lite_read(12'h010, d);
        check("status_idle", d, 0);
        lite_read(12'h000, d);
        check("ctrl_read", d, 0);
        lite_read(12'h020, d);
        check("unmapped_read", d, 0);
        lite_write(12'h008, 32'h0, 4'hF);
        lite_write(12'h008, 32'hFFFF_FFFF, 4'b0101);
        lite_read(12'h008, d);
        check("wstrb", d, 32'h00FF_00FF);

        for (int i = 0; i < 64; i++) rows[i] = 64'hDEAD_BEEF_CAFE_BABE;
        run_bfs("fix64", 64, 32'h1234_5678, 32'h1000, -1, 1'b1);
        check("fix64_spec_status", last_status, 32'h0001_2F02);
        check("fix64_spec_lo", last_lo, 32'hCAFE_BABE);
        check("fix64_spec_hi", last_hi, 32'hDFAD_BEEF);
        check("fix64_first_addr", first_addr, 32'h0000_11C0);
        run_bfs("n32", 32, 32'h1234_5678, 32'h1000, -1, 1'b0);
        check("n32_spec_status", last_status, 32'h0000_0006);
        run_bfs("rresp", 64, 5, 32'h2000, 0, 1'b0);
        check("rresp_spec_status", last_status, 32'h0000_0106);

        for (int i = 0; i < 64; i++) rows[i] = (i < 63) ? (64'd1 << (i + 1)) : 64'd0;
        run_bfs("chain", 64, 0, 32'h0004_0000, -1, 1'b0);
        check("chain_spec_status", last_status, 32'h003F_4002);
        run_bfs("num0", 0, 0, 32'h100, -1, 1'b0);
        run_bfs("num65", 65, 0, 32'h100, -1, 1'b0);
        run_bfs("start_eq_num", 10, 10, 32'h100, -1, 1'b0);
        run_bfs("one_node", 1, 0, 32'h100, -1, 1'b0);

        // reset while a master read address is outstanding
        for (int i = 0; i < 64; i++) rows[i] = 64'hDEAD_BEEF_CAFE_BABE;
        build_model(64, 56, 32'h1000, -1);
        program_and_start(64, 56, 32'h1000);
        k = 0;
        while (!(m_axi_arvalid && ridx >= 2) && k < 4000) begin @(negedge clk); k++; end
        check("mid_arvalid_seen", m_axi_arvalid, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_outs", {m_axi_arvalid, m_axi_rready, s_axi_lite_awready, s_axi_lite_wready,
                               s_axi_lite_bvalid, s_axi_lite_arready, s_axi_lite_rvalid, global_done}, 0);
        check("mid_rst_araddr", m_axi_araddr, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        lite_read(12'h010, d);
        check("mid_rst_status", d, 0);
        lite_read(12'h004, d);
        check("mid_rst_start_reg", d, 0);
        run_bfs("after_rst", 64, 56, 32'h1000, -1, 1'b0);

        for (int r = 0; r < 10; r++) begin
            k = $urandom_range(1, 4);
            for (int i = 0; i < 64; i++) begin
                v = {$urandom, $urandom};
                for (int j = 1; j < k; j++) v = v & {$urandom, $urandom};
                rows[i] = v;
            end
            num   = $urandom_range(1, 64);
            start = ($urandom & 32'hFFFF_FFC0) | $urandom_range(0, int'(num) - 1);
            base  = $urandom & 32'h00FF_FFF8;
            e     = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 5) : -1;
            run_bfs($sformatf("rand%0d", r), num, start, base, e, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
